// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA layer arbiter.
// Holds the colour format, miss colour, rank-width helper, reset rank table
// and the configuration FSM state type.
package vga_pkg;

    localparam int unsigned COLOR_W    = 12;
    localparam logic [COLOR_W-1:0] BG_COLOR = 12'h000;
    localparam int unsigned MAX_LAYERS = 8;
    localparam int unsigned MISS_W     = 16;

    // Identity ordering: layer i starts with rank i.
    localparam int unsigned RESET_RANK [MAX_LAYERS] = '{0, 1, 2, 3, 4, 5, 6, 7};

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

    // clog2 over the supported layer range (2..8), never below 1 bit.
    function automatic int unsigned rank_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end else if (n <= 4) begin
            return 2;
        end else begin
            return 3;
        end
    endfunction

endpackage

// File: rtl/vga_prio_select.sv
// Combinational priority picker.
// Ports: valid_i/mask_i per-layer request and enable, rank_i packed ranks
// (rank 0 = highest priority); winner_o one-hot winner, hit_o any candidate.
module vga_prio_select
    import vga_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned RANK_W     = rank_width(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0]        valid_i,
    input  logic [NUM_LAYERS-1:0]        mask_i,
    input  logic [NUM_LAYERS*RANK_W-1:0] rank_i,
    output logic [NUM_LAYERS-1:0]        winner_o,
    output logic                         hit_o
);

    logic [RANK_W-1:0] best_rank;

    // Strict less-than keeps the lower index on equal ranks.
    always_comb begin
        winner_o  = '0;
        hit_o     = 1'b0;
        best_rank = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (valid_i[i] && mask_i[i] &&
                (!hit_o || (rank_i[i*RANK_W +: RANK_W] < best_rank))) begin
                winner_o    = '0;
                winner_o[i] = 1'b1;
                hit_o       = 1'b1;
                best_rank   = rank_i[i*RANK_W +: RANK_W];
            end
        end
    end

endmodule

// File: rtl/vga_layer_arbiter.sv
// Per-pixel layer arbiter for the VGA datapath.
// Ports: pixel_clk/reset (async, active-high); video_enable, frame_start
// timing from VGA_Top; layer_valid/layer_color per-layer pixels;
// cfg_valid/cfg_ready/cfg_rank/cfg_mask config handshake; cfg_pending config
// waiting for frame_start; color_data/grant registered winner; miss_count
// misses in the last completed frame.
module vga_layer_arbiter
    import vga_pkg::rank_width;
    import vga_pkg::RESET_RANK;
    import vga_pkg::MISS_W;
    import vga_pkg::cfg_state_e;
    import vga_pkg::CFG_IDLE;
    import vga_pkg::CFG_PENDING;
#(
    parameter int unsigned        NUM_LAYERS = 4,
    parameter int unsigned        COLOR_W    = vga_pkg::COLOR_W,
    parameter int unsigned        RANK_W     = rank_width(NUM_LAYERS),
    parameter logic [COLOR_W-1:0] BG_COLOR   = vga_pkg::BG_COLOR
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic                          video_enable,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [NUM_LAYERS*RANK_W-1:0]  cfg_rank,
    input  logic [NUM_LAYERS-1:0]         cfg_mask,
    output logic                          cfg_pending,
    output logic [COLOR_W-1:0]            color_data,
    output logic [NUM_LAYERS-1:0]         grant,
    output logic [MISS_W-1:0]             miss_count
);

    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    function automatic logic [NUM_LAYERS*RANK_W-1:0] reset_ranks();
        logic [NUM_LAYERS*RANK_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            r[i*RANK_W +: RANK_W] = RANK_W'(RESET_RANK[i]);
        end
        return r;
    endfunction

    localparam logic [NUM_LAYERS*RANK_W-1:0] RANK_RST = reset_ranks();

    cfg_state_e                   state_q, state_d;
    logic [NUM_LAYERS*RANK_W-1:0] shadow_rank_q, shadow_rank_d;
    logic [NUM_LAYERS-1:0]        shadow_mask_q, shadow_mask_d;
    logic [NUM_LAYERS*RANK_W-1:0] active_rank_q, active_rank_d;
    logic [NUM_LAYERS-1:0]        active_mask_q, active_mask_d;
    logic [COLOR_W-1:0]           color_q, color_d;
    logic [NUM_LAYERS-1:0]        grant_q, grant_d;
    logic [MISS_W-1:0]            run_q, run_d;
    logic [MISS_W-1:0]            miss_q, miss_d;

    logic [NUM_LAYERS-1:0]        winner;
    logic                         hit;
    logic [COLOR_W-1:0]           win_color;
    logic                         miss_c;

    vga_prio_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .RANK_W     (RANK_W)
    ) u_prio_select (
        .valid_i  (layer_valid),
        .mask_i   (active_mask_q),
        .rank_i   (active_rank_q),
        .winner_o (winner),
        .hit_o    (hit)
    );

    // One-hot colour mux.
    always_comb begin
        win_color = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (winner[i]) begin
                win_color = win_color | layer_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // Pixel output; blanking forces black and is never a miss.
    always_comb begin
        color_d = '0;
        grant_d = '0;
        miss_c  = 1'b0;
        if (video_enable) begin
            if (hit) begin
                color_d = win_color;
                grant_d = winner;
            end else begin
                color_d = BG_COLOR;
                miss_c  = 1'b1;
            end
        end
    end

    // Miss counter; frame_start publishes and restarts, counting its own cycle.
    always_comb begin
        run_d  = run_q;
        miss_d = miss_q;
        if (frame_start) begin
            miss_d = run_q;
            run_d  = miss_c ? MISS_W'(1) : '0;
        end else if (miss_c && (run_q != MISS_MAX)) begin
            run_d = run_q + MISS_W'(1);
        end
    end

    // Config FSM: capture into shadow, apply at the next frame boundary.
    always_comb begin
        state_d       = state_q;
        shadow_rank_d = shadow_rank_q;
        shadow_mask_d = shadow_mask_q;
        active_rank_d = active_rank_q;
        active_mask_d = active_mask_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    shadow_rank_d = cfg_rank;
                    shadow_mask_d = cfg_mask;
                    state_d       = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (frame_start) begin
                    active_rank_d = shadow_rank_q;
                    active_mask_d = shadow_mask_q;
                    state_d       = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q       <= CFG_IDLE;
            shadow_rank_q <= '0;
            shadow_mask_q <= '0;
            active_rank_q <= RANK_RST;
            active_mask_q <= '1;
            color_q       <= '0;
            grant_q       <= '0;
            run_q         <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            shadow_rank_q <= shadow_rank_d;
            shadow_mask_q <= shadow_mask_d;
            active_rank_q <= active_rank_d;
            active_mask_q <= active_mask_d;
            color_q       <= color_d;
            grant_q       <= grant_d;
            run_q         <= run_d;
            miss_q        <= miss_d;
        end
    end

    assign cfg_ready   = (state_q == CFG_IDLE);
    assign cfg_pending = (state_q == CFG_PENDING);
    assign color_data  = color_q;
    assign grant       = grant_q;
    assign miss_count  = miss_q;

endmodule
